// File: rtl/decoder_3x8_strobe_pkg.sv
// decoder_3x8_strobe_pkg: FSM state encoding, default widths and
// hold-counter sizing shared by the strobe decoder files.
package decoder_3x8_strobe_pkg;

    localparam int DEF_CODE_W      = 3;
    localparam int DEF_DATA_W      = 1 << DEF_CODE_W;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_HOLD_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Hold counter counts HOLD_CYCLES-1 down to 0; keep at least 1 bit.
    function automatic int hold_cnt_w(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/decoder_3x8_strobe_if.sv
// decoder_3x8_strobe_if: valid/ready code input channel.
// Ports: in_valid, in_code (master->slave), in_ready (slave->master).
interface decoder_3x8_strobe_if
    import decoder_3x8_strobe_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W
);

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );

endinterface

// File: rtl/decoder_3x8_strobe_sync_fifo.sv
// decoder_3x8_strobe_sync_fifo: single-clock FIFO, power-of-2 depth.
// Ports: clk, rst_n, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o.
module decoder_3x8_strobe_sync_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // full_o depends on count only: a full FIFO refuses a push
    // even on an edge where it is also popped.
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/decoder_3x8_strobe.sv
// decoder_3x8_strobe: queued binary-to-one-hot decoder, each word held
// HOLD_CYCLES cycles. Ports: clk, rst_n, in_if (slave: in_valid, in_code,
// in_ready), data_out, out_active, busy, fifo_count.
// DECODER_3X8_GAP_EN inserts one all-zero cycle between words.
module decoder_3x8_strobe
    import decoder_3x8_strobe_pkg::*;
#(
    parameter  int CODE_W      = DEF_CODE_W,
    parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
    localparam int DATA_W      = 1 << CODE_W,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_3x8_strobe_if.slave in_if,
    output logic [DATA_W-1:0]   data_out,
    output logic                out_active,
    output logic                busy,
    output logic [CNT_W-1:0]    fifo_count
);

    localparam int HCW = hold_cnt_w(HOLD_CYCLES);

    state_t            state_q;
    logic [HCW-1:0]    hold_q;
    logic [DATA_W-1:0] data_q;
    logic              act_q;

    logic [CODE_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              hold_run;
    logic              hold_end;

    decoder_3x8_strobe_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_if.in_valid),
        .wdata_i (in_if.in_code),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign in_if.in_ready = !full;

`ifdef DECODER_3X8_GAP_EN
    // A finished word always passes through GAP before the next load.
    assign pop = !empty && (state_q != ST_HOLD);
`else
    assign pop = !empty &&
                 ((state_q != ST_HOLD) || (hold_q == '0));
`endif

    assign hold_run = (state_q == ST_HOLD) && (hold_q != '0);
    assign hold_end = (state_q == ST_HOLD) && (hold_q == '0) && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            unique case (1'b1)
                pop: begin
                    state_q <= ST_HOLD;
                    hold_q  <= HCW'(HOLD_CYCLES - 1);
                    data_q  <= DATA_W'(1) << head;
                    act_q   <= 1'b1;
                end
                hold_run: begin
                    hold_q <= hold_q - HCW'(1);
                end
                hold_end: begin
`ifdef DECODER_3X8_GAP_EN
                    state_q <= ST_GAP;
`else
                    state_q <= ST_IDLE;
`endif
                    data_q  <= '0;
                    act_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    data_q  <= '0;
                    act_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign out_active = act_q;
    assign busy       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_decoder_3x8_strobe.sv
// tb_decoder_3x8_strobe: directed bench with scoreboard for the
// 3-to-8 strobe decoder (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_decoder_3x8_strobe;

    localparam int HOLD = 4;
`ifdef DECODER_3X8_GAP_EN
    localparam int FULL_E = 3;
    localparam int IDLE_E = 3;
    localparam int H1_SPAN = 14;
`else
    localparam int FULL_E = 2;
    localparam int IDLE_E = 2;
    localparam int H1_SPAN = 7;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_3x8_strobe_if #(.CODE_W(3)) if0 ();
    decoder_3x8_strobe_if #(.CODE_W(3)) if1 ();

    logic [7:0] d0, d1;
    logic       a0, a1, b0, b1;
    logic [2:0] c0, c1;

    decoder_3x8_strobe #(
        .CODE_W(3), .FIFO_DEPTH(4), .HOLD_CYCLES(HOLD)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0),
        .data_out(d0), .out_active(a0), .busy(b0), .fifo_count(c0)
    );

    decoder_3x8_strobe #(
        .CODE_W(3), .FIFO_DEPTH(4), .HOLD_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1),
        .data_out(d1), .out_active(a1), .busy(b1), .fifo_count(c1)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    int run = 0;
    logic [7:0] prev = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] code, output int edges);
        logic rdy;
        edges = 0;
        rdy = 1'b0;
        if0.in_valid = 1'b1;
        if0.in_code = code;
        while (!rdy && edges < 50) begin
            @(negedge clk);
            rdy = if0.in_ready;
            @(posedge clk);
            #1;
            edges++;
        end
        chk("push_timeout", rdy, 1);
        if (rdy) sb.push_back(8'h01 << code);
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (b0 !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", b0, 0);
    endtask

    function automatic logic [7:0] b2b_exp(input int idx);
`ifdef DECODER_3X8_GAP_EN
        if (idx < 4) return 8'h01;
        if (idx == 4) return 8'h00;
        if (idx < 9) return 8'h80;
        if (idx == 9) return 8'h00;
        if (idx < 14) return 8'h04;
        return 8'h00;
`else
        if (idx < 4) return 8'h01;
        if (idx < 8) return 8'h80;
        if (idx < 12) return 8'h04;
        return 8'h00;
`endif
    endfunction

    // Scoreboard monitor for dut0: each new word pops one expectation,
    // every word must last exactly HOLD cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            run = 0;
            prev = '0;
        end else begin
            chk("mon_known", $isunknown(d0), 0);
            chk("mon_active", a0, d0 != 8'h00);
            chk("mon_onehot", $countones(d0) <= 1, 1);
            if (d0 != 8'h00) begin
                if (run == 0 || run == HOLD) begin
                    chk("sb_unexpected", sb.size() != 0, 1);
                    if (sb.size() != 0) chk("sb_word", d0, sb.pop_front());
                    run = 1;
                end else begin
                    chk("sb_held", d0, prev);
                    run++;
                end
                prev = d0;
            end else begin
                if (run != 0) chk("sb_len", run, HOLD);
                run = 0;
            end
        end
    end

    initial begin
        int e;
        logic [7:0] exp1[$];
        logic [7:0] w;
        logic rdy1;
        int i, first, last, nobs;

        rst_n = 1'b0;
        if0.in_valid = 1'b0;
        if0.in_code = '0;
        if1.in_valid = 1'b0;
        if1.in_code = '0;

        // reset state, and no write while in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", d0, 0);
        chk("rst_active", a0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_count", c0, 0);
        chk("rst_ready", if0.in_ready, 1);
        if0.in_valid = 1'b1;
        if0.in_code = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nowrite", c0, 0);
        if0.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_data", d0, 0);
        chk("rel_busy", b0, 0);

        // single code 3: latency one edge, held HOLD cycles
        push(3'd3, e);
        chk("single_lat", d0, 0);
        chk("single_cnt", c0, 1);
        chk("single_busy", b0, 1);
        for (int k = 0; k < HOLD; k++) begin
            @(posedge clk);
            #1;
            chk("single_hold", d0, 8'h08);
            chk("single_act", a0, 1);
        end
        @(posedge clk);
        #1;
        chk("single_end", d0, 0);
        chk("single_act_end", a0, 0);
        wait_idle();

        // back-to-back 0,7,2
        push(3'd0, e);
        push(3'd7, e);
        push(3'd2, e);
        for (int idx = 1; idx < 16; idx++) begin
            chk("b2b_word", d0, b2b_exp(idx));
            chk("b2b_act", a0, b2b_exp(idx) != 8'h00);
            @(posedge clk);
            #1;
        end
        wait_idle();

        // full FIFO: fifth queued code waits past the pop edge
        push(3'd1, e);
        push(3'd6, e);
        push(3'd2, e);
        push(3'd5, e);
        push(3'd3, e);
        chk("full_cnt", c0, 4);
        chk("full_ready", if0.in_ready, 0);
        push(3'd4, e);
        chk("full_wait", e, FULL_E);
        chk("full_cnt2", c0, 4);
        wait_idle();
        chk("full_drained", sb.size(), 0);

        // simultaneous push/pop at count 2
        push(3'd1, e);
        push(3'd4, e);
        push(3'd7, e);
        chk("pp_cnt0", c0, 2);
        repeat (IDLE_E) @(posedge clk);
        #1;
        chk("pp_cnt1", c0, 2);
        push(3'd5, e);
        chk("pp_edges", e, 1);
        chk("pp_cnt2", c0, 2);
        chk("pp_pop", d0, 8'h10);
        for (int k = 0; k < 8; k++) begin
            push(3'((k * 3 + 2) % 8), e);
        end
        wait_idle();
        chk("stream_drained", sb.size(), 0);

        // HOLD_CYCLES=1 exhaustive stream on dut1
        i = 0;
        first = -1;
        last = -1;
        nobs = 0;
        if1.in_valid = 1'b1;
        if1.in_code = 3'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("h1_act", a1, d1 != 8'h00);
            if (d1 != 8'h00) begin
                chk("h1_unexpected", exp1.size() != 0, 1);
                if (exp1.size() != 0) chk("h1_word", d1, exp1.pop_front());
                if (first < 0) first = c;
                last = c;
                nobs++;
            end
            rdy1 = if1.in_ready;
            @(posedge clk);
            #1;
            if (if1.in_valid && rdy1) begin
                w = 8'h01;
                exp1.push_back(w << i);
                i++;
                if (i == 8) if1.in_valid = 1'b0;
                else if1.in_code = 3'(i);
            end
        end
        chk("h1_sent", i, 8);
        chk("h1_nobs", nobs, 8);
        chk("h1_span", last - first, H1_SPAN);
        chk("h1_left", exp1.size(), 0);
        chk("h1_busy", b1, 0);
        chk("h1_cnt", c1, 0);

        // reset mid-hold of code 5 discards queued codes
        push(3'd5, e);
        push(3'd1, e);
        push(3'd2, e);
        chk("rmid_pre", d0, 8'h20);
        rst_n = 1'b0;
        #1;
        chk("rmid_data", d0, 0);
        chk("rmid_act", a0, 0);
        chk("rmid_cnt", c0, 0);
        chk("rmid_busy", b0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("rmid_quiet", d0, 0);
            chk("rmid_idle", b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
